// File: rtl/rast_perf_counter_if.sv
// Snapshot export port of the rasterizer performance counters.
// The counter block drives the captured fields; the consumer drives the
// request/accept side of the handshake.
interface rast_perf_counter_if #(
  parameter int CNT_W = 32
);
  logic             snap_req;
  logic             snap_ready;
  logic             snap_valid;
  logic [CNT_W-1:0] snap_cycles;
  logic [CNT_W-1:0] snap_tris;
  logic [CNT_W-1:0] snap_stalls;
  logic [CNT_W-1:0] snap_samps;
  logic [CNT_W-1:0] snap_hits;
  logic [4:0]       snap_ovf;
  logic             snap_overrun;

  modport master (
    input  snap_req, snap_ready,
    output snap_valid, snap_cycles, snap_tris, snap_stalls, snap_samps,
           snap_hits, snap_ovf, snap_overrun
  );

  modport slave (
    output snap_req, snap_ready,
    input  snap_valid, snap_cycles, snap_tris, snap_stalls, snap_samps,
           snap_hits, snap_ovf, snap_overrun
  );
endinterface

// File: rtl/rast_perf_counter.sv
// Saturating rasterizer event counters (cycles, triangles, stalls, samples,
// hits) with a snapshot register exported over a valid/ready handshake.
// Counter index order matches snap_ovf bit order: 0 cycles, 1 tris,
// 2 stalls, 3 samps, 4 hits.
module rast_perf_counter #(
  parameter int SAMPS   = 4,
  parameter int CNT_W   = 32,
  parameter int WIN_LG2 = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 validTri_R10H,
  input  logic                 halt_RnnnnL,
  input  logic                 validSamp_R16H,
  input  logic [SAMPS-1:0]     hit_valid_R18H,
  input  logic                 enable,
  input  logic                 mode,
  input  logic                 clr,
  rast_perf_counter_if.master  snap
);
  localparam int NCNT = 5;
  localparam int PC_W = $clog2(SAMPS + 1);

  // live state
  logic [NCNT-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NCNT-1:0]            ovf_q, ovf_d;
  logic [WIN_LG2-1:0]         win_q, win_d;
  logic                       mode_q, mode_d;

  // snapshot state
  logic [NCNT-1:0][CNT_W-1:0] snap_cnt_q, snap_cnt_d;
  logic [NCNT-1:0]            snap_ovf_q, snap_ovf_d;
  logic                       snap_valid_q, snap_valid_d;
  logic                       snap_overrun_q, snap_overrun_d;

  // inclusive next-state values (counters plus this cycle's increments)
  logic [NCNT-1:0][CNT_W-1:0] inc;
  logic [NCNT-1:0][CNT_W:0]   sum;
  logic [NCNT-1:0][CNT_W-1:0] cnt_nxt;
  logic [NCNT-1:0]            ovf_nxt;
  logic [PC_W-1:0]            pop;
  logic                       snap_evt;
  logic                       win_wrap;

  // Per-cycle increments, saturation and sticky overflow detection.
  always_comb begin
    pop = '0;
    for (int l = 0; l < SAMPS; l++) pop = pop + PC_W'(hit_valid_R18H[l]);

    inc    = '0;
    inc[0] = CNT_W'(1);
    inc[1] = CNT_W'(validTri_R10H & halt_RnnnnL);
    inc[2] = CNT_W'(validTri_R10H & ~halt_RnnnnL);
    inc[3] = validSamp_R16H ? CNT_W'(SAMPS) : '0;
    inc[4] = CNT_W'(pop);

    sum     = '0;
    cnt_nxt = cnt_q;
    ovf_nxt = ovf_q;
    for (int i = 0; i < NCNT; i++) begin
      sum[i] = {1'b0, cnt_q[i]} + {1'b0, inc[i]};
      if (enable) begin
        // a carry out means the true count passed the maximum: pin it there
        if (sum[i][CNT_W]) begin
          cnt_nxt[i] = '1;
          ovf_nxt[i] = 1'b1;
        end else begin
          cnt_nxt[i] = sum[i][CNT_W-1:0];
        end
      end
    end
  end

  // Snapshot trigger, live-counter update and window counter.
  always_comb begin
    // window wraps only on an enabled cycle, so a frozen block never fires
    win_wrap = enable & (&win_q);
    snap_evt = mode_q ? win_wrap : snap.snap_req;
    mode_d   = mode;

    cnt_d = cnt_nxt;
    ovf_d = ovf_nxt;
    if (clr || (snap_evt && mode_q)) begin
      // clear discards this cycle's events; windowed snapshot restarts at 0
      cnt_d = '0;
      ovf_d = '0;
    end

    win_d = win_q;
    if (clr || (mode != mode_q)) win_d = '0;
    else if (enable)             win_d = win_q + 1'b1;
  end

  // Snapshot register and handshake; a new snapshot beats a same-cycle accept.
  always_comb begin
    snap_cnt_d     = snap_cnt_q;
    snap_ovf_d     = snap_ovf_q;
    snap_valid_d   = snap_valid_q;
    snap_overrun_d = snap_overrun_q;
    if (snap_evt) begin
      snap_cnt_d   = cnt_nxt;
      snap_ovf_d   = ovf_nxt;
      snap_valid_d = 1'b1;
      if (snap_valid_q && !snap.snap_ready) snap_overrun_d = 1'b1;
    end else if (snap_valid_q && snap.snap_ready) begin
      snap_valid_d = 1'b0;
    end
    if (clr) snap_overrun_d = 1'b0;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q          <= '0;
      ovf_q          <= '0;
      win_q          <= '0;
      mode_q         <= 1'b0;
      snap_cnt_q     <= '0;
      snap_ovf_q     <= '0;
      snap_valid_q   <= 1'b0;
      snap_overrun_q <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      ovf_q          <= ovf_d;
      win_q          <= win_d;
      mode_q         <= mode_d;
      snap_cnt_q     <= snap_cnt_d;
      snap_ovf_q     <= snap_ovf_d;
      snap_valid_q   <= snap_valid_d;
      snap_overrun_q <= snap_overrun_d;
    end
  end

  assign snap.snap_valid   = snap_valid_q;
  assign snap.snap_cycles  = snap_cnt_q[0];
  assign snap.snap_tris    = snap_cnt_q[1];
  assign snap.snap_stalls  = snap_cnt_q[2];
  assign snap.snap_samps   = snap_cnt_q[3];
  assign snap.snap_hits    = snap_cnt_q[4];
  assign snap.snap_ovf     = snap_ovf_q;
  assign snap.snap_overrun = snap_overrun_q;
endmodule

// File: tb/tb_rast_perf_counter.sv
// Directed bench for rast_perf_counter (SAMPS=4, CNT_W=8, WIN_LG2=3).
module tb_rast_perf_counter;
  localparam int SAMPS = 4;
  localparam int CNT_W = 8;
  localparam int WIN_LG2 = 3;

  logic clk = 1'b0;
  logic rst;
  logic validTri_R10H, halt_RnnnnL, validSamp_R16H;
  logic [SAMPS-1:0] hit_valid_R18H;
  logic enable, mode, clr;

  int vecs = 0;
  int errs = 0;

  rast_perf_counter_if #(.CNT_W(CNT_W)) sif ();

  rast_perf_counter #(.SAMPS(SAMPS), .CNT_W(CNT_W), .WIN_LG2(WIN_LG2)) dut (
    .clk            (clk),
    .rst            (rst),
    .validTri_R10H  (validTri_R10H),
    .halt_RnnnnL    (halt_RnnnnL),
    .validSamp_R16H (validSamp_R16H),
    .hit_valid_R18H (hit_valid_R18H),
    .enable         (enable),
    .mode           (mode),
    .clr            (clr),
    .snap           (sif)
  );

  always #5 clk = ~clk;

  // one clock edge; inputs set beforehand apply to it, outputs read 1ns later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_events();
    validTri_R10H  = 1'b0;
    halt_RnnnnL    = 1'b1;
    validSamp_R16H = 1'b0;
    hit_valid_R18H = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; mode = 1'b0; clr = 1'b0;
    sif.snap_req = 1'b0; sif.snap_ready = 1'b0;
    idle_events();
    tick(); tick();
    rst = 1'b0;
    vecs++; if (sif.snap_valid !== 1'b0) begin errs++; $display("FAIL reset_valid: got %0d want 0", sif.snap_valid); end
    vecs++; if (sif.snap_cycles !== 8'd0 || sif.snap_tris !== 8'd0 || sif.snap_stalls !== 8'd0 || sif.snap_samps !== 8'd0 || sif.snap_hits !== 8'd0) begin
      errs++; $display("FAIL reset_fields: got %0d %0d %0d %0d %0d want all 0", sif.snap_cycles, sif.snap_tris, sif.snap_stalls, sif.snap_samps, sif.snap_hits); end
    vecs++; if (sif.snap_ovf !== 5'd0 || sif.snap_overrun !== 1'b0) begin errs++; $display("FAIL reset_flags: got ovf %b overrun %0d want 0 0", sif.snap_ovf, sif.snap_overrun); end
  endtask

  task automatic test_cumulative();
    enable = 1'b1; mode = 1'b0;
    for (int i = 0; i < 10; i++) begin
      validTri_R10H  = 1'b1;
      halt_RnnnnL    = (i < 6);
      validSamp_R16H = (i == 1 || i == 4 || i == 7);
      hit_valid_R18H = (i == 2) ? 4'b1011 : (i == 5) ? 4'b0001 : 4'b0000;
      tick();
    end
    idle_events();
    vecs++; if (sif.snap_valid !== 1'b0) begin errs++; $display("FAIL cum_prevalid: got %0d want 0", sif.snap_valid); end
    sif.snap_req = 1'b1; tick(); sif.snap_req = 1'b0;
    vecs++; if (sif.snap_valid !== 1'b1) begin errs++; $display("FAIL cum_valid: got %0d want 1", sif.snap_valid); end
    vecs++; if (sif.snap_cycles !== 8'd11) begin errs++; $display("FAIL cum_cycles: got %0d want 11", sif.snap_cycles); end
    vecs++; if (sif.snap_tris !== 8'd6) begin errs++; $display("FAIL cum_tris: got %0d want 6", sif.snap_tris); end
    vecs++; if (sif.snap_stalls !== 8'd4) begin errs++; $display("FAIL cum_stalls: got %0d want 4", sif.snap_stalls); end
    vecs++; if (sif.snap_samps !== 8'd12) begin errs++; $display("FAIL cum_samps: got %0d want 12", sif.snap_samps); end
    vecs++; if (sif.snap_hits !== 8'd4) begin errs++; $display("FAIL cum_hits: got %0d want 4", sif.snap_hits); end
    // valid holds until accepted
    tick();
    vecs++; if (sif.snap_valid !== 1'b1) begin errs++; $display("FAIL cum_hold: got %0d want 1", sif.snap_valid); end
    sif.snap_ready = 1'b1; tick(); sif.snap_ready = 1'b0;
    vecs++; if (sif.snap_valid !== 1'b0) begin errs++; $display("FAIL cum_accept: got %0d want 0", sif.snap_valid); end
  endtask

  task automatic test_saturate();
    clr = 1'b1; tick(); clr = 1'b0;
    for (int i = 0; i < 70; i++) begin
      validSamp_R16H = 1'b1;
      sif.snap_req = (i == 69);
      tick();
    end
    sif.snap_req = 1'b0; idle_events();
    vecs++; if (sif.snap_samps !== 8'd255) begin errs++; $display("FAIL sat_samps: got %0d want 255", sif.snap_samps); end
    vecs++; if (sif.snap_cycles !== 8'd70) begin errs++; $display("FAIL sat_cycles: got %0d want 70", sif.snap_cycles); end
    vecs++; if (sif.snap_ovf !== 5'b01000) begin errs++; $display("FAIL sat_ovf: got %b want 01000", sif.snap_ovf); end
    vecs++; if (sif.snap_overrun !== 1'b0) begin errs++; $display("FAIL sat_overrun: got %0d want 0", sif.snap_overrun); end
    sif.snap_ready = 1'b1; tick(); sif.snap_ready = 1'b0;
  endtask

  task automatic test_windowed();
    mode = 1'b1; clr = 1'b1; tick(); clr = 1'b0;
    sif.snap_ready = 1'b1;
    hit_valid_R18H = 4'b1111;
    for (int k = 1; k <= 24; k++) begin
      tick();
      vecs++; if (sif.snap_valid !== (k % 8 == 0)) begin errs++; $display("FAIL win_valid_%0d: got %0d want %0d", k, sif.snap_valid, (k % 8 == 0)); end
      if (k % 8 == 0) begin
        vecs++; if (sif.snap_hits !== 8'd32 || sif.snap_cycles !== 8'd8) begin
          errs++; $display("FAIL win_counts_%0d: got hits %0d cycles %0d want 32 8", k, sif.snap_hits, sif.snap_cycles); end
      end
    end
    idle_events();
    mode = 1'b0; tick(); tick();
    sif.snap_ready = 1'b0;
  endtask

  task automatic test_overrun();
    clr = 1'b1; tick(); clr = 1'b0;
    validTri_R10H = 1'b1; halt_RnnnnL = 1'b1;
    sif.snap_req = 1'b1; tick(); sif.snap_req = 1'b0;
    tick(); tick();
    sif.snap_req = 1'b1; tick(); sif.snap_req = 1'b0;
    vecs++; if (sif.snap_cycles !== 8'd4 || sif.snap_tris !== 8'd4) begin errs++; $display("FAIL ovr_data: got cycles %0d tris %0d want 4 4", sif.snap_cycles, sif.snap_tris); end
    vecs++; if (sif.snap_overrun !== 1'b1) begin errs++; $display("FAIL ovr_flag: got %0d want 1", sif.snap_overrun); end
    clr = 1'b1; tick(); clr = 1'b0;
    vecs++; if (sif.snap_overrun !== 1'b0) begin errs++; $display("FAIL ovr_clr: got %0d want 0", sif.snap_overrun); end
    vecs++; if (sif.snap_valid !== 1'b1 || sif.snap_cycles !== 8'd4) begin errs++; $display("FAIL ovr_keep: got valid %0d cycles %0d want 1 4", sif.snap_valid, sif.snap_cycles); end
    sif.snap_ready = 1'b1; sif.snap_req = 1'b1; tick(); sif.snap_req = 1'b0;
    vecs++; if (sif.snap_valid !== 1'b1 || sif.snap_overrun !== 1'b0) begin errs++; $display("FAIL ovr_win: got valid %0d overrun %0d want 1 0", sif.snap_valid, sif.snap_overrun); end
    vecs++; if (sif.snap_cycles !== 8'd1 || sif.snap_tris !== 8'd1) begin errs++; $display("FAIL ovr_newdata: got cycles %0d tris %0d want 1 1", sif.snap_cycles, sif.snap_tris); end
    idle_events(); tick();
    vecs++; if (sif.snap_valid !== 1'b0) begin errs++; $display("FAIL ovr_drain: got %0d want 0", sif.snap_valid); end
    sif.snap_ready = 1'b0;
  endtask

  task automatic test_enable_rst();
    clr = 1'b1; tick(); clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      validTri_R10H = 1'b1; halt_RnnnnL = 1'b1; validSamp_R16H = 1'b1; hit_valid_R18H = 4'b1111;
      tick();
    end
    enable = 1'b0;
    for (int i = 0; i < 20; i++) begin
      halt_RnnnnL = i[0];
      sif.snap_req = (i == 19);
      tick();
    end
    sif.snap_req = 1'b0;
    vecs++; if (sif.snap_cycles !== 8'd5 || sif.snap_tris !== 8'd5 || sif.snap_stalls !== 8'd0) begin
      errs++; $display("FAIL en_cnt: got %0d %0d %0d want 5 5 0", sif.snap_cycles, sif.snap_tris, sif.snap_stalls); end
    vecs++; if (sif.snap_samps !== 8'd20 || sif.snap_hits !== 8'd20) begin errs++; $display("FAIL en_samp: got %0d %0d want 20 20", sif.snap_samps, sif.snap_hits); end
    // leave a snapshot pending, then reset in the middle of a window
    enable = 1'b1; mode = 1'b1;
    tick(); tick(); tick();
    vecs++; if (sif.snap_valid !== 1'b1) begin errs++; $display("FAIL rst_pending: got %0d want 1", sif.snap_valid); end
    rst = 1'b1; tick();
    vecs++; if (sif.snap_valid !== 1'b0) begin errs++; $display("FAIL rst_valid: got %0d want 0", sif.snap_valid); end
    vecs++; if (sif.snap_cycles !== 8'd0 || sif.snap_tris !== 8'd0 || sif.snap_samps !== 8'd0 || sif.snap_hits !== 8'd0 || sif.snap_ovf !== 5'd0 || sif.snap_overrun !== 1'b0) begin
      errs++; $display("FAIL rst_fields: got %0d %0d %0d %0d %b %0d want zeros", sif.snap_cycles, sif.snap_tris, sif.snap_samps, sif.snap_hits, sif.snap_ovf, sif.snap_overrun); end
    rst = 1'b0; mode = 1'b0; idle_events(); tick();
  endtask

  initial begin
    test_reset();
    test_cumulative();
    test_saturate();
    test_windowed();
    test_overrun();
    test_enable_rst();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/rast_perf_counter.md
# rast_perf_counter

Synthesizable, parametrised performance counter block for the rasterizer pipeline, replacing the simulation-only cycle/triangle/sample/hit tally in the bench monitors. It taps the R10 triangle handshake, the R16 sample-valid strobe and the R18 per-lane hit vector. It accumulates saturating event counts and exports them through a snapshot register with a valid/ready handshake. It adds a stall counter, per-counter overflow flags and an auto-snapshot windowed mode.

## Interface
- SAMPS, 4: sample lanes per cycle (hit_valid width, sample increment)
- CNT_W, 32: width of every counter and snapshot field
- WIN_LG2, 10: log2 of the window length in cycles for windowed mode
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- validTri_R10H  in  1  triangle offered at R10
- halt_RnnnnL  in  1  pipeline halt, active low (0 = stalled)
- validSamp_R16H  in  1  SAMPS samples tested this cycle
- hit_valid_R18H  in  SAMPS  per-lane hit
- enable  in  1  count events while 1
- mode  in  1  0 = cumulative, 1 = windowed
- clr  in  1  zero live counters and flags
- snap_req  in  1  request snapshot (cumulative mode)
- snap_ready  in  1  consumer accepts snapshot
- snap_valid  out  1  snapshot fields valid
- snap_cycles, snap_tris, snap_stalls, snap_samps, snap_hits  out  CNT_W each  captured counts
- snap_ovf  out  5  captured overflow flags {hits,samps,stalls,tris,cycles}
- snap_overrun  out  1  sticky: a snapshot overwrote an unconsumed one

## Operation
- Per-cycle increments, only when enable=1: cycles +1; tris +1 if validTri_R10H & halt_RnnnnL; stalls +1 if validTri_R10H & !halt_RnnnnL; samps +SAMPS if validSamp_R16H; hits +popcount(hit_valid_R18H), width $clog2(SAMPS+1).
- Each counter saturates at 2^CNT_W-1. An increment that would exceed the maximum leaves the counter at the maximum and sets its live overflow flag, which stays set.
- Snapshot event: cumulative mode when snap_req=1; windowed mode when the window counter (WIN_LG2 bits, advances only while enable=1) wraps from all-ones to 0. snap_req is ignored in windowed mode.
- On a snapshot event, snap_* load the inclusive next-state values, i.e. counters plus the current cycle's increments. snap_ovf loads the next-state flags, and snap_valid is set.
  - Windowed mode: live counters and flags then restart at 0.
  - Cumulative mode: live counters continue.
- Handshake: snap_valid & snap_ready clears snap_valid the next cycle. A snapshot event in the same cycle wins: snap_valid stays 1 with the new data and no overrun.
- A snapshot event while snap_valid=1 & snap_ready=0 overwrites snap_* and sets snap_overrun.
- clr=1: live counters, live flags, window counter and snap_overrun go to 0. The current cycle's events are discarded.
- clr and a snapshot event in the same cycle: the snapshot captures the pre-clear inclusive values, then counters are 0.
- Changing mode takes effect next cycle. The window counter resets to 0 on any mode change.
- enable=0 freezes all counters and the window counter. Snapshot events still occur: a snap_req is honoured, and no window wrap can happen.

## Timing
- Reset: all live counters, window counter, flags = 0; snap_valid=0; all snap_* fields = 0; snap_ovf=0; snap_overrun=0.
- Event at cycle N is visible in live counters at N+1.
- snap_req at cycle N gives snap_valid=1 and fields at N+1.
- Windowed snapshot fires on the 2^WIN_LG2-th enabled cycle after clear or reset.
- rst asserted mid-operation: full reset next edge, including a pending snapshot, which is dropped.
- No combinational path from inputs to outputs.

## Test plan
- Test 1, SAMPS=4, cumulative mode, enable=1. Stimulus: 10 cycles with validTri=1, halt=1 on cycles 0–5 and halt=0 on 6–9; validSamp=1 on 3 cycles; hit vectors 4'b1011, 4'b0001. Then snap_req.
  - Required: cycles=11, tris=6, stalls=4, samps=12, hits=4, snap_valid next cycle.
- Test 2, CNT_W=8. Stimulus: validSamp=1 for 70 cycles.
  - Required: samps holds at 255 and snap_ovf[3]=1; cycles=70 (snapshot taken in cycle 70) with its flag clear.
- Test 3, windowed mode, WIN_LG2=3, hit vector 4'b1111 every cycle.
  - Required: snap_valid pulses every 8 cycles with hits=32 and cycles=8 each time; live counters are 0 after each snapshot.
- Test 4, snap_ready=0, two snap_req 3 cycles apart.
  - Required: second snapshot's values are shown and snap_overrun=1.
  - Then clr=1: snap_overrun=0.
  - Then snap_ready=1 with a simultaneous snap_req: snap_valid stays 1.
- Test 5, enable=0 for 20 cycles with all events active.
  - Required: counters unchanged. Then rst mid-window: all outputs 0 and snap_valid=0 next cycle.
